// File: rtl/secuencia_pkg.sv
// secuencia_pkg: state encoding and helper function shared by the secuencia_* blocks.
//   S_IDLE/S_SHIFT/S_GAP/S_DONE : 2-bit state codes, wrapped in the state_e enum
//   clog2(n)                    : bits needed to hold values 0..n-1 (never less than 1)
package secuencia_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = S_IDLE,
        StShift = S_SHIFT,
        StGap   = S_GAP,
        StDone  = S_DONE
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/secuencia_tick.sv
// secuencia_tick: DIV prescaler for the bit shifter.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   clear_i  : restart the count (new burst loaded)
//   en_i     : count while a pattern bit is being held
//   tick_o   : one-cycle pulse on the last cycle of each bit period
module secuencia_tick
    import secuencia_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned   CntW = clog2(DIV + 1);
    localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    assign tick_o = en_i && !clear_i && (cnt_q == Last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/secuencia_generador.sv
// secuencia_generador: serial bit-sequence transmitter feeding the secuencia_* detectors.
// Shifts PATTERN out MSB-first, each bit held DIV cycles, repeated reps times per burst.
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset, aborts any burst
//   start_i      : burst request, sampled only in idle
//   reps_i[3:0]  : repetitions per burst (0 treated as 1), latched on start
//   w_o          : serial data
//   bit_valid_o  : w_o carries a pattern bit
//   busy_o       : burst in progress
//   done_o       : one-cycle pulse after the last bit
// Build option: define SEQ_GAP_EN to insert GAP idle cycles (w_o=0, busy_o=1) between repetitions.
module secuencia_generador
    import secuencia_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] PATTERN = 8'b0110_1110,
    parameter int unsigned      DIV     = 1,
    parameter int unsigned      GAP     = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] reps_i,
    output logic       w_o,
    output logic       bit_valid_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned     BitW    = clog2(WIDTH + 1);
    localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [BitW-1:0]  bit_q;
    logic [3:0]       rep_q;
    logic             w_q;
    logic             bit_valid_q;
    logic             busy_q;
    logic             done_q;

    logic load;
    logic bit_tick;

`ifdef SEQ_GAP_EN
    localparam int unsigned     GapW    = clog2(GAP + 1);
    localparam logic [GapW-1:0] LastGap = GapW'(GAP - 1);

    logic [GapW-1:0] gap_q;
`endif

    assign load = (state_q == StIdle) && start_i;

    secuencia_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (load),
        .en_i    (state_q == StShift),
        .tick_o  (bit_tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_q       <= '0;
            rep_q       <= '0;
            w_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_GAP_EN
            gap_q       <= '0;
`endif
        end else begin
            // Outputs are a registered decode of the current state, so they trail it by one
            // cycle and never see an input combinationally.
            w_q         <= (state_q == StShift) && shift_q[WIDTH-1];
            bit_valid_q <= (state_q == StShift);
            busy_q      <= (state_q == StShift) || (state_q == StGap);
            done_q      <= (state_q == StDone);

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        shift_q <= PATTERN;
                        rep_q   <= (reps_i == 4'd0) ? 4'd1 : reps_i;
                        bit_q   <= '0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (bit_tick) begin
                        if (bit_q == LastBit) begin
                            bit_q <= '0;
                            if (rep_q > 4'd1) begin
                                // Reload so the next rep's first bit follows without a hole.
                                rep_q   <= rep_q - 4'd1;
                                shift_q <= PATTERN;
`ifdef SEQ_GAP_EN
                                gap_q   <= '0;
                                state_q <= StGap;
`endif
                            end else begin
                                state_q <= StDone;
                            end
                        end else begin
                            bit_q   <= bit_q + BitW'(1);
                            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                StGap: begin
`ifdef SEQ_GAP_EN
                    if (gap_q == LastGap) begin
                        state_q <= StShift;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
`else
                    state_q <= StIdle;
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign w_o         = w_q;
    assign bit_valid_o = bit_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
